pipeline_hazard_ctrl: RTL and testbench

Hazard and stall controller for the five-stage pipeline. It drives the enable and flush inputs of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves three conditions:
- load-use data hazards, by inserting a bubble;
- taken branches resolved in MEM, by flushing the wrong-path instructions;
- multi-cycle data-memory accesses, by freezing the whole pipeline with timeout protection.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 12 +
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and default sizing for the pipeline hazard/stall controller.
package hazard_pkg;
    localparam int REG_W           = 5;
    localparam int MEM_TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle: hazard inputs from ID/EX/MEM and the register enable/flush controls.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = hazard_pkg::REG_W,
    parameter int CNT_W = hazard_pkg::CNT_W_DEF
);
    // mem_req/mem_ready form a level handshake: an access completes in any cycle
    // where both are high; mem_req with mem_ready low means the pipeline must hold.
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] idex_rt;
    logic             idex_memread;
    logic             exmem_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, idex_rt, idex_memread, exmem_branch_taken,
               mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, idex_rt, idex_memread, exmem_branch_taken,
               mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use bubble, MEM-stage branch flush and memory-freeze controller with timeout.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus,
    output hz_state_t              state
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q;
    logic              load_use, active, stall_inc;
    logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic              ifid_flush, idex_flush, exmem_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= (state_d == ERROR);
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    assign load_use = bus.idex_memread && (bus.idex_rt != '0) &&
                      ((bus.idex_rt == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.idex_rt == bus.id_rt)));

    // The release cycle of a freeze behaves exactly like a RUN cycle.
    assign active = reset &&
                    (((state_q == RUN) && !(bus.mem_req && !bus.mem_ready)) ||
                     ((state_q == MEM_WAIT) && bus.mem_ready));

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (active) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (bus.exmem_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    assign stall_inc = reset && !pc_en && (state_q != ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (bus.stall_cycles)
    );

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.mem_timeout = timeout_q;
    assign state           = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with a 4-bit counter covers saturation.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam logic [7:0] C_NONE = 8'b00000_000;
    localparam logic [7:0] C_RUN  = 8'b11111_000;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_BR   = 8'b11111_111;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
    logic id_uses_rt = 1'b0, idex_memread = 1'b0, br = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    hz_state_t st, st4;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();
    pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  bus4 ();

    assign bus.id_rs = id_rs;            assign bus4.id_rs = id_rs;
    assign bus.id_rt = id_rt;            assign bus4.id_rt = id_rt;
    assign bus.id_uses_rt = id_uses_rt;  assign bus4.id_uses_rt = id_uses_rt;
    assign bus.idex_rt = idex_rt;        assign bus4.idex_rt = idex_rt;
    assign bus.idex_memread = idex_memread; assign bus4.idex_memread = idex_memread;
    assign bus.exmem_branch_taken = br;  assign bus4.exmem_branch_taken = br;
    assign bus.mem_req = mem_req;        assign bus4.mem_req = mem_req;
    assign bus.mem_ready = mem_ready;    assign bus4.mem_ready = mem_ready;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .state(st));
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .state(st4));

    wire [7:0] ctrl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                       bus.ifid_flush, bus.idex_flush, bus.exmem_flush};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic rd, input logic [4:0] ert, input logic [4:0] rs,
                          input logic [4:0] rt, input logic use_rt);
        idex_memread = rd; idex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = use_rt;
        #1;
    endtask

    initial begin
        // Reset held: everything idle.
        #2;
        check_eq("rst_ctrl", 32'(ctrl), 32'(C_NONE));
        check_eq("rst_stall", 32'(bus.stall_cycles), 0);
        check_eq("rst_timeout", 32'(bus.mem_timeout), 0);
        check_eq("rst_state", 32'(st), 32'(RUN));
        tick(); tick();
        reset = 1'b1;
        #1;
        check_eq("idle_ctrl", 32'(ctrl), 32'(C_RUN));

        // Load-use on rs: one-cycle bubble.
        set_lu(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        check_eq("lu_rs_ctrl", 32'(ctrl), 32'(C_LU));
        tick(); exp_stall++;
        set_lu(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_eq("lu_after_ctrl", 32'(ctrl), 32'(C_RUN));
        check_eq("lu_stall", 32'(bus.stall_cycles), 32'(exp_stall));
        // Load-use on rt only counts when the ID instruction reads rt.
        set_lu(1'b1, 5'd7, 5'd3, 5'd7, 1'b1);
        check_eq("lu_rt_ctrl", 32'(ctrl), 32'(C_LU));
        set_lu(1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
        check_eq("lu_rt_unused", 32'(ctrl), 32'(C_RUN));
        set_lu(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        idex_memread = 1'b0; #1;
        check_eq("lu_noload", 32'(ctrl), 32'(C_RUN));
        set_lu(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        check_eq("lu_r0", 32'(ctrl), 32'(C_RUN));
        tick();
        check_eq("lu_r0_stall", 32'(bus.stall_cycles), 32'(exp_stall));

        // Branch flush overrides a simultaneous load-use.
        set_lu(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        br = 1'b1; #1;
        check_eq("br_ctrl", 32'(ctrl), 32'(C_BR));
        tick();
        check_eq("br_stall", 32'(bus.stall_cycles), 32'(exp_stall));
        br = 1'b0;
        set_lu(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Memory wait: 3 cycles without ready, then release.
        mem_req = 1'b1; mem_ready = 1'b0; #1;
        check_eq("mw_ctrl0", 32'(ctrl), 32'(C_NONE));
        tick(); exp_stall++;
        check_eq("mw_state", 32'(st), 32'(MEM_WAIT));
        check_eq("mw_ctrl1", 32'(ctrl), 32'(C_NONE));
        tick(); exp_stall++;
        check_eq("mw_ctrl2", 32'(ctrl), 32'(C_NONE));
        tick(); exp_stall++;
        mem_ready = 1'b1; #1;
        check_eq("mw_release", 32'(ctrl), 32'(C_RUN));
        tick();
        mem_req = 1'b0; mem_ready = 1'b0; #1;
        check_eq("mw_back_run", 32'(st), 32'(RUN));
        check_eq("mw_stall", 32'(bus.stall_cycles), 32'(exp_stall));
        check_eq("mw_stall4", 32'(bus4.stall_cycles), 32'(exp_stall));
        mem_req = 1'b1; mem_ready = 1'b1; #1;
        check_eq("mw_hit_nostall", 32'(ctrl), 32'(C_RUN));
        tick();
        check_eq("mw_hit_state", 32'(st), 32'(RUN));
        mem_req = 1'b0; mem_ready = 1'b0;

        // Branch pending across a 2-cycle freeze: flush only in the release cycle.
        br = 1'b1; mem_req = 1'b1; #1;
        check_eq("rb_frz0", 32'(ctrl), 32'(C_NONE));
        tick(); exp_stall++;
        check_eq("rb_frz1", 32'(ctrl), 32'(C_NONE));
        tick(); exp_stall++;
        mem_ready = 1'b1; #1;
        check_eq("rb_release", 32'(ctrl), 32'(C_BR));
        tick();
        br = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; #1;
        check_eq("rb_stall", 32'(bus.stall_cycles), 32'(exp_stall));

        // Reset in the middle of a freeze.
        mem_req = 1'b1;
        tick(); tick();
        check_eq("mr_state", 32'(st), 32'(MEM_WAIT));
        reset = 1'b0; #1;
        check_eq("mr_state_rst", 32'(st), 32'(RUN));
        check_eq("mr_stall_rst", 32'(bus.stall_cycles), 0);
        check_eq("mr_ctrl_rst", 32'(ctrl), 32'(C_NONE));
        mem_req = 1'b0;
        tick();
        reset = 1'b1; #1;

        // Timeout: ready held low; ERROR after the 15th MEM_WAIT cycle.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        check_eq("to_pre_state", 32'(st), 32'(MEM_WAIT));
        check_eq("to_pre_flag", 32'(bus.mem_timeout), 0);
        check_eq("to_pre_stall", 32'(bus.stall_cycles), 15);
        check_eq("sat_pre", 32'(bus4.stall_cycles), 15);
        tick();
        check_eq("to_state", 32'(st), 32'(ERROR));
        check_eq("to_flag", 32'(bus.mem_timeout), 1);
        check_eq("to_stall", 32'(bus.stall_cycles), 16);
        check_eq("sat_cap", 32'(bus4.stall_cycles), 15);
        for (int i = 0; i < 4; i++) tick();
        mem_ready = 1'b1; br = 1'b1; #1;
        check_eq("to_hold_state", 32'(st), 32'(ERROR));
        check_eq("to_hold_ctrl", 32'(ctrl), 32'(C_NONE));
        check_eq("to_hold_flag", 32'(bus.mem_timeout), 1);
        check_eq("to_hold_stall", 32'(bus.stall_cycles), 16);
        reset = 1'b0; #1;
        check_eq("to_rst_flag", 32'(bus.mem_timeout), 0);
        check_eq("to_rst_state", 32'(st), 32'(RUN));
        check_eq("to_rst_stall4", 32'(bus4.stall_cycles), 0);
        br = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        tick();
        reset = 1'b1; #1;
        check_eq("post_ctrl", 32'(ctrl), 32'(C_RUN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
